mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 22 ++
 rtl/mem_subword_align.sv | 44 ++++
 rtl/mem_access_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, wb_ctrl layout, defaults.
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DEST_W  = 3;
  localparam int DEF_TIMEOUT = 15;

  // wb_ctrl = {wb_en, wb_dest, wb_mux}; wb_mux is bit 0 and wb_dest starts at bit 1
  localparam int WB_MUX_POS  = 0;
  localparam int WB_DEST_LSB = 1;

  function automatic int wb_en_pos(input int dest_w);
    return dest_w + 1;
  endfunction

endpackage

// File: rtl/mem_subword_align.sv
// Byte-lane helper: byte enables and store replication on the request side,
// byte select with zero/sign extension on the response side.
module mem_subword_align #(
  parameter int DATA_W = 16,
  parameter int LANE_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
  input  logic                  req_byte,
  input  logic [LANE_W-1:0]     req_lane,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     wdata,
  input  logic                  rsp_byte,
  input  logic                  rsp_sext,
  input  logic [LANE_W-1:0]     rsp_lane,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [DATA_W-1:0]     rd_aligned
);

  localparam int NB = DATA_W / 8;

  logic [7:0] byte_sel;

  always_comb begin
    be    = '1;
    wdata = wr_data;
    if (req_byte) begin
      be    = '0;
      wdata = {NB{wr_data[7:0]}};
      for (int i = 0; i < NB; i++) begin
        if (req_lane == LANE_W'(i)) be[i] = 1'b1;
      end
    end
  end

  always_comb begin
    byte_sel = rd_data[7:0];
    for (int i = 0; i < NB; i++) begin
      if (rsp_lane == LANE_W'(i)) byte_sel = rd_data[i*8 +: 8];
    end
    if (rsp_byte) rd_aligned = {{(DATA_W-8){rsp_sext & byte_sel[7]}}, byte_sel};
    else          rd_aligned = rd_data;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one memory request per load/store with an ack timeout,
// registers the WB payload. Byte access is enabled with MEM_ACCESS_SUBWORD_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. in_ready is
// independent of in_valid; out_valid, once set, holds its payload until out_ready.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEST_W  = DEF_DEST_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic                  in_mem_rd,
  input  logic                  in_mem_wr,
  input  logic [DATA_W-1:0]     in_wr_data,
  input  logic                  in_byte,
  input  logic                  in_sext,
  input  logic [DEST_W+1:0]     in_wb_ctrl,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_rd_data,
  output logic [DEST_W+1:0]     out_wb_ctrl,
  output logic                  hz_valid,
  output logic [DEST_W-1:0]     hz_dest,
  output logic                  bus_err
);

  localparam int WB_W   = DEST_W + 2;
  localparam int NB     = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int LANE_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;
  localparam logic [WB_W-1:0] WB_EN_MASK = WB_W'(1) << wb_en_pos(DEST_W);

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept, start_mem, finish, tmo;

  logic [WB_W-1:0]   wb_q;
  logic [DATA_W-1:0] alu_q;
  logic [NB-1:0]     be_req;
  logic [DATA_W-1:0] wdata_req;
  logic [DATA_W-1:0] rd_aligned;

`ifdef MEM_ACCESS_SUBWORD_EN
  logic byte_q, sext_q;

  mem_subword_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_align (
    .req_byte   (in_byte),
    .req_lane   (in_alu_result[LANE_W-1:0]),
    .wr_data    (in_wr_data),
    .be         (be_req),
    .wdata      (wdata_req),
    .rsp_byte   (byte_q),
    .rsp_sext   (sext_q),
    .rsp_lane   (mem_addr[LANE_W-1:0]),
    .rd_data    (mem_rdata),
    .rd_aligned (rd_aligned)
  );
`else
  logic unused_subword;
  assign unused_subword = ^{in_byte, in_sext};
  assign be_req     = '1;
  assign wdata_req  = in_wr_data;
  assign rd_aligned = mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    start_mem = 1'b0;
    finish    = 1'b0;
    tmo       = 1'b0;
    in_ready  = (state == IDLE) && (!out_valid || out_ready);
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          if (in_mem_rd || in_mem_wr) begin
            start_mem = 1'b1;
            state_d   = ACCESS;
            cnt_d     = '0;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          finish  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // this cycle is the TIMEOUT-th without an ack
          finish  = 1'b1;
          tmo     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hz_valid = (state == ACCESS);
  assign hz_dest  = hz_valid ? wb_q[WB_DEST_LSB +: DEST_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      wb_q           <= '0;
      alu_q          <= '0;
      out_valid      <= 1'b0;
      out_alu_result <= '0;
      out_rd_data    <= '0;
      out_wb_ctrl    <= '0;
      bus_err        <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
      byte_q         <= 1'b0;
      sext_q         <= 1'b0;
`endif
    end else begin
      if (start_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= in_mem_wr;
        mem_addr  <= in_alu_result[ADDR_W-1:0];
        mem_wdata <= wdata_req;
        mem_be    <= be_req;
        wb_q      <= in_wb_ctrl;
        alu_q     <= in_alu_result;
`ifdef MEM_ACCESS_SUBWORD_EN
        byte_q    <= in_byte;
        sext_q    <= in_sext;
`endif
      end else if (finish) begin
        mem_req <= 1'b0;
      end

      if (tmo) bus_err <= 1'b1;

      if (accept && !start_mem) begin
        out_valid      <= 1'b1;
        out_alu_result <= in_alu_result;
        out_rd_data    <= '0;
        out_wb_ctrl    <= in_wb_ctrl;
      end else if (finish) begin
        out_valid      <= 1'b1;
        out_alu_result <= alu_q;
        out_rd_data    <= (tmo || mem_we) ? '0 : rd_aligned;
        out_wb_ctrl    <= tmo ? (wb_q & ~WB_EN_MASK) : wb_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
